sprite_palette_bank: RTL and testbench
======================================

Name: sprite_palette_bank

Overview:
- Writable, multi-bank colour palette that replaces the fixed per-sprite palette ROMs.
- Maps a sprite pixel index plus a bank select to 12-bit RGB through a 2-stage registered lookup.
- Adds colour-key transparency and a frame-stepped global fade to black and back.
- Sits between the sprite ROM/renderer and the VGA colour mux; loaded at runtime by the game-logic FSM.

Parameters:
- INDEX_W, 4, pixel index width; 2^INDEX_W entries per bank
- BANKS, 4, number of palette banks (power of 2, >=2)
- COLOR_W, 4, bits per colour channel
- TRANSP_INDEX, 0, index treated as transparent when transp_en=1
- FADE_DIV, 4, frame_tick pulses per fade step (>=1)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  palette write strobe
- wr_bank  in  log2(BANKS)  bank to write
- wr_index  in  INDEX_W  entry to write
- wr_color  in  3*COLOR_W  {R,G,B} to store
- rd_valid  in  1  pixel lookup request
- rd_bank  in  log2(BANKS)  bank to read
- rd_index  in  INDEX_W  pixel index
- transp_en  in  1  enable colour-key for this pixel
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- fade_start  in  1  begin fade
- fade_dir  in  1  0 = fade out (to black), 1 = fade in
- out_valid  out  1  lookup result valid
- red, green, blue  out  COLOR_W each  scaled colour
- out_transp  out  1  pixel transparent
- fade_busy  out  1  fade in progress
- fade_level  out  4  current brightness, 15 = full

Behaviour:
- Reset (async, Reset_n=0):
  - all palette entries = 0
  - pipeline valids, out_valid, RGB and out_transp = 0
  - fade_level = 15, fade_busy = 0, divider counter = 0
- Storage: BANKS x 2^INDEX_W registers of 3*COLOR_W bits.
- Write: wr_en=1 updates entry [wr_bank][wr_index] at the clock edge. No handshake; a write is accepted every cycle.
- Lookup pipeline: fixed latency 2, no backpressure. rd_valid in cycle N gives out_valid in cycle N+2. Back-to-back requests run at 1 per cycle, in order.
  - Stage 1 registers: valid, transparency flag (transp_en && rd_index==TRANSP_INDEX), and the raw entry.
  - Stage 2 registers: scaled colour and the flag into the outputs.
- Read/write collision on the same entry in the same cycle: the read returns the old value. A read issued the next cycle returns the new value.
- When out_valid=0, outputs hold their last values.
- Transparent pixel: out_transp=1 and RGB forced to 0, regardless of palette content and fade.
- Fade scaling, per channel, in stage 2: out = (c * (fade_level+1)) >> 4, computed at COLOR_W+5 bits and truncated to COLOR_W. Uses the fade_level value present in the stage-2 cycle.
  - Level 15 gives exact passthrough; level 0 gives 0 for COLOR_W <= 4.
- Fade FSM states: IDLE, FADE_OUT, FADE_IN.
  - fade_start=1 (any state): enter FADE_OUT if fade_dir=0, FADE_IN if fade_dir=1. Divider counter cleared, fade_busy=1 from the next cycle, level kept (a fade reverses from the current level).
  - In a FADE state, each frame_tick increments the divider. On reaching FADE_DIV, the divider clears and the level steps by 1 (down for out, up for in).
  - Reaching level 0 (out) or 15 (in) returns the FSM to IDLE and drops fade_busy the same edge.
  - fade_start while already at the target level: enter the FADE state, then return to IDLE on the next frame_tick with no level change.
  - fade_start and frame_tick in the same cycle: start wins, the tick is discarded.
  - frame_tick in IDLE: ignored.
- Reset asserted mid-fade or mid-lookup: all state returns to reset values immediately. In-flight lookups are dropped (no out_valid).

Test Plan:
- Reset, then rd_valid, bank 0, index 5: out_valid 2 cycles later with RGB=0,0,0 and out_transp=0; fade_level=15, fade_busy=0.
- Write bank 2 index 3 = 0xF,0xC,0x7; read bank 2 index 3 and bank 1 index 3 back to back: outputs F,C,7 then 0,0,0 in consecutive cycles.
- Same-cycle write of 0x999 and read of that entry (old value 0x444): read returns 0x444; a read the next cycle returns 0x999.
- transp_en=1, index 0, entry = 0xFFF: out_transp=1, RGB=0. Same request with transp_en=0: RGB=F,F,F and out_transp=0.
- fade_start with dir=0, FADE_DIV=4, then 60 frame_ticks: level falls by 1 every 4 ticks and reaches 0 after tick 60, fade_busy drops. Entry 0xFC7 reads 0xFC7 at level 15, 0x7,0x6,0x3 at level 7, 0x000 at level 0.
- Mid-fade at level 9: fade_start dir=1 coincident with frame_tick -> FSM in FADE_IN, level still 9, divider 0; level reaches 15 after 24 further ticks. Reset_n pulse mid-fade restores level 15 and busy 0 asynchronously.

Source files
------------

// File: rtl/sprite_palette_bank_if.sv
// Write, lookup and fade signals of the sprite palette bank.
// master drives requests and fade control, slave returns scaled colour.
interface sprite_palette_bank_if #(
    parameter int INDEX_W = 4,
    parameter int BANKS   = 4,
    parameter int COLOR_W = 4
);
    localparam int BANK_W = $clog2(BANKS);

    logic                   wr_en;
    logic [BANK_W-1:0]      wr_bank;
    logic [INDEX_W-1:0]     wr_index;
    logic [3*COLOR_W-1:0]   wr_color;
    logic                   rd_valid;
    logic [BANK_W-1:0]      rd_bank;
    logic [INDEX_W-1:0]     rd_index;
    logic                   transp_en;
    logic                   frame_tick;
    logic                   fade_start;
    logic                   fade_dir;
    logic                   out_valid;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   out_transp;
    logic                   fade_busy;
    logic [3:0]             fade_level;

    modport master (
        output wr_en, wr_bank, wr_index, wr_color,
        output rd_valid, rd_bank, rd_index, transp_en,
        output frame_tick, fade_start, fade_dir,
        input  out_valid, red, green, blue, out_transp,
        input  fade_busy, fade_level
    );

    modport slave (
        input  wr_en, wr_bank, wr_index, wr_color,
        input  rd_valid, rd_bank, rd_index, transp_en,
        input  frame_tick, fade_start, fade_dir,
        output out_valid, red, green, blue, out_transp,
        output fade_busy, fade_level
    );
endinterface

// File: rtl/sprite_palette_bank.sv
// Writable multi-bank sprite palette: 2-stage lookup with colour-key
// transparency and a frame-stepped global fade.
module sprite_palette_bank #(
    parameter int INDEX_W      = 4,
    parameter int BANKS        = 4,
    parameter int COLOR_W      = 4,
    parameter int TRANSP_INDEX = 0,
    parameter int FADE_DIV     = 4
) (
    input logic            Clk,
    input logic            Reset_n,
    sprite_palette_bank_if.slave bus
);
    localparam int BANK_W  = $clog2(BANKS);
    localparam int ADDR_W  = BANK_W + INDEX_W;
    localparam int ENTRIES = 1 << ADDR_W;
    localparam int CW3     = 3 * COLOR_W;
    localparam int PW      = COLOR_W + 5;
    localparam int DIV_W   = $clog2(FADE_DIV + 1);

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_e;

    logic [CW3-1:0]     pal_q [ENTRIES];
    logic [CW3-1:0]     pal_d [ENTRIES];
    logic               s1_valid_q, s1_valid_d;
    logic               s1_transp_q, s1_transp_d;
    logic [CW3-1:0]     s1_color_q, s1_color_d;
    logic               out_valid_q, out_valid_d;
    logic               out_transp_q, out_transp_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;
    fade_state_e        state_q, state_d;
    logic [3:0]         level_q, level_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               busy_q, busy_d;
    logic [DIV_W-1:0]   div_inc;
    logic               at_target;

    function automatic logic [COLOR_W-1:0] scale(
        input logic [COLOR_W-1:0] c,
        input logic [3:0]         lvl
    );
        logic [PW-1:0] p;
        p = PW'(c) * PW'({1'b0, lvl} + 5'd1);
        return p[COLOR_W+3:4];
    endfunction

    always_comb begin
        pal_d = pal_q;
        if (bus.wr_en)
            pal_d[{bus.wr_bank, bus.wr_index}] = bus.wr_color;
    end

    // Stage 1 reads pal_q, so a same-cycle write is seen only by later reads
    always_comb begin
        s1_valid_d  = bus.rd_valid;
        s1_transp_d = bus.rd_valid && bus.transp_en &&
                      (bus.rd_index == INDEX_W'(TRANSP_INDEX));
        s1_color_d  = s1_color_q;
        if (bus.rd_valid)
            s1_color_d = pal_q[{bus.rd_bank, bus.rd_index}];
    end

    always_comb begin
        out_valid_d  = s1_valid_q;
        out_transp_d = out_transp_q;
        red_d        = red_q;
        green_d      = green_q;
        blue_d       = blue_q;
        if (s1_valid_q) begin
            out_transp_d = s1_transp_q;
            if (s1_transp_q) begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end else begin
                red_d   = scale(s1_color_q[CW3-1 -: COLOR_W], level_q);
                green_d = scale(s1_color_q[2*COLOR_W-1 -: COLOR_W], level_q);
                blue_d  = scale(s1_color_q[COLOR_W-1:0], level_q);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        div_d     = div_q;
        busy_d    = busy_q;
        div_inc   = div_q + DIV_W'(1);
        at_target = (state_q == FADE_OUT) ? (level_q == 4'd0)
                                          : (level_q == 4'd15);
        if (bus.fade_start) begin
            state_d = bus.fade_dir ? FADE_IN : FADE_OUT;
            div_d   = '0;
            busy_d  = 1'b1;
        end else if (bus.frame_tick && state_q != IDLE) begin
            if (at_target) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                div_d   = '0;
            end else if (div_inc == DIV_W'(FADE_DIV)) begin
                div_d   = '0;
                level_d = (state_q == FADE_OUT) ? level_q - 4'd1
                                                : level_q + 4'd1;
                if (level_d == 4'd0 || level_d == 4'd15) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end else begin
                div_d = div_inc;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ENTRIES; i++)
                pal_q[i] <= '0;
        end else begin
            pal_q <= pal_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_transp_q  <= 1'b0;
            s1_color_q   <= '0;
            out_valid_q  <= 1'b0;
            out_transp_q <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_transp_q  <= s1_transp_d;
            s1_color_q   <= s1_color_d;
            out_valid_q  <= out_valid_d;
            out_transp_q <= out_transp_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            level_q <= 4'd15;
            div_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_transp = out_transp_q;
    assign bus.red        = red_q;
    assign bus.green      = green_q;
    assign bus.blue       = blue_q;
    assign bus.fade_busy  = busy_q;
    assign bus.fade_level = level_q;
endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed and random checks of sprite_palette_bank against a
// behavioural palette/fade model.
module tb_sprite_palette_bank;
    localparam int IW = 4;
    localparam int NB = 4;
    localparam int CW = 4;
    localparam int TI = 0;
    localparam int FD = 4;
    localparam int NE = 1 << IW;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_on = 0;

    sprite_palette_bank_if #(.INDEX_W(IW), .BANKS(NB), .COLOR_W(CW)) bus();

    sprite_palette_bank #(
        .INDEX_W(IW), .BANKS(NB), .COLOR_W(CW),
        .TRANSP_INDEX(TI), .FADE_DIV(FD)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    // Model state
    logic [11:0] pal [NB][NE];
    bit          s1_v, s1_t;
    logic [11:0] s1_c;
    bit          exp_v, exp_t;
    int          exp_rgb;
    bit          act;
    int          s_lvl, fdir, ticks;

    function automatic int lvl_now();
        int v;
        v = fdir ? s_lvl + ticks / FD : s_lvl - ticks / FD;
        if (v < 0) v = 0;
        if (v > 15) v = 15;
        return v;
    endfunction

    function automatic int scl(int c, int l);
        return (c * (l + 1)) / 16;
    endfunction

    task automatic chk(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        int L;
        if (!Reset_n) begin
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < NE; i++)
                    pal[b][i] = '0;
            s1_v = 0; s1_t = 0; s1_c = '0;
            exp_v = 0; exp_t = 0; exp_rgb = 0;
            act = 0; s_lvl = 15; fdir = 0; ticks = 0;
        end else begin
            L = lvl_now();
            exp_v = s1_v;
            if (s1_v) begin
                exp_t = s1_t;
                exp_rgb = s1_t ? 0 :
                    (scl(int'(s1_c[11:8]), L) << 8) |
                    (scl(int'(s1_c[7:4]), L) << 4) |
                     scl(int'(s1_c[3:0]), L);
            end
            s1_v = bus.rd_valid;
            if (bus.rd_valid) begin
                s1_t = bus.transp_en && (int'(bus.rd_index) == TI);
                s1_c = pal[bus.rd_bank][bus.rd_index];
            end
            if (bus.wr_en)
                pal[bus.wr_bank][bus.wr_index] = bus.wr_color;
            if (bus.fade_start) begin
                s_lvl = L; fdir = int'(bus.fade_dir); ticks = 0; act = 1;
            end else if (act && bus.frame_tick) begin
                ticks++;
                if (lvl_now() == (fdir != 0 ? 15 : 0)) act = 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("m_valid", int'(bus.out_valid), int'(exp_v));
            chk("m_rgb", int'({bus.red, bus.green, bus.blue}), exp_rgb);
            chk("m_transp", int'(bus.out_transp), int'(exp_t));
            chk("m_level", int'(bus.fade_level), lvl_now());
            chk("m_busy", int'(bus.fade_busy), int'(act));
        end
    end

    task automatic clr();
        bus.wr_en = 0; bus.wr_bank = '0; bus.wr_index = '0; bus.wr_color = '0;
        bus.rd_valid = 0; bus.rd_bank = '0; bus.rd_index = '0;
        bus.transp_en = 0; bus.frame_tick = 0; bus.fade_start = 0;
        bus.fade_dir = 0;
    endtask

    task automatic wr(int b, int i, int c);
        bus.wr_en = 1; bus.wr_bank = 2'(b); bus.wr_index = 4'(i);
        bus.wr_color = 12'(c);
        @(negedge Clk);
        bus.wr_en = 0;
    endtask

    task automatic rd_chk(string nm, int b, int i, bit t, int rgb, bit et);
        bus.rd_valid = 1; bus.rd_bank = 2'(b); bus.rd_index = 4'(i);
        bus.transp_en = t;
        @(negedge Clk);
        bus.rd_valid = 0; bus.transp_en = 0;
        @(negedge Clk);
        chk({nm, "_v"}, int'(bus.out_valid), 1);
        chk({nm, "_rgb"}, int'({bus.red, bus.green, bus.blue}), rgb);
        chk({nm, "_t"}, int'(bus.out_transp), int'(et));
    endtask

    task automatic tick(int n);
        repeat (n) begin
            bus.frame_tick = 1;
            @(negedge Clk);
            bus.frame_tick = 0;
            @(negedge Clk);
        end
    endtask

    task automatic start(bit d);
        bus.fade_start = 1; bus.fade_dir = d;
        @(negedge Clk);
        bus.fade_start = 0;
    endtask

    task automatic lvl_chk(string nm, int l, bit b);
        chk({nm, "_lvl"}, int'(bus.fade_level), l);
        chk({nm, "_busy"}, int'(bus.fade_busy), int'(b));
    endtask

    initial begin
        clr();
        repeat (3) @(negedge Clk);
        lvl_chk("rst", 15, 0);
        chk("rst_v", int'(bus.out_valid), 0);
        Reset_n = 1;
        chk_on = 1;
        @(negedge Clk);

        rd_chk("rd0", 0, 5, 0, 'h000, 0);
        lvl_chk("rd0", 15, 0);

        wr(2, 3, 'hFC7);
        bus.rd_valid = 1; bus.rd_bank = 2; bus.rd_index = 3;
        @(negedge Clk);
        bus.rd_bank = 1;
        @(negedge Clk);
        bus.rd_valid = 0;
        chk("b2b_a", int'({bus.red, bus.green, bus.blue}), 'hFC7);
        @(negedge Clk);
        chk("b2b_b", int'({bus.red, bus.green, bus.blue}), 'h000);
        chk("b2b_bv", int'(bus.out_valid), 1);

        wr(3, 4, 'h444);
        bus.wr_en = 1; bus.wr_bank = 3; bus.wr_index = 4; bus.wr_color = 'h999;
        bus.rd_valid = 1; bus.rd_bank = 3; bus.rd_index = 4;
        @(negedge Clk);
        bus.wr_en = 0;
        @(negedge Clk);
        bus.rd_valid = 0;
        chk("coll_old", int'({bus.red, bus.green, bus.blue}), 'h444);
        @(negedge Clk);
        chk("coll_new", int'({bus.red, bus.green, bus.blue}), 'h999);

        wr(0, 0, 'hFFF);
        rd_chk("tr_on", 0, 0, 1, 'h000, 1);
        rd_chk("tr_off", 0, 0, 0, 'hFFF, 0);

        wr(1, 1, 'hFC7);
        rd_chk("f15", 1, 1, 0, 'hFC7, 0);
        start(0);
        lvl_chk("fo_st", 15, 1);
        tick(24);
        lvl_chk("fo_9", 9, 1);
        bus.fade_start = 1; bus.fade_dir = 1; bus.frame_tick = 1;
        @(negedge Clk);
        clr();
        lvl_chk("rev", 9, 1);
        tick(23);
        lvl_chk("fi_14", 14, 1);
        tick(1);
        lvl_chk("fi_15", 15, 0);

        start(0);
        tick(32);
        lvl_chk("fo_7", 7, 1);
        rd_chk("f7", 1, 1, 0, 'h763, 0);
        tick(27);
        lvl_chk("fo_1", 1, 1);
        tick(1);
        lvl_chk("fo_0", 0, 0);
        rd_chk("f0", 1, 1, 0, 'h000, 0);
        start(0);
        lvl_chk("tgt_st", 0, 1);
        tick(1);
        lvl_chk("tgt_end", 0, 0);

        start(1);
        tick(10);
        lvl_chk("fi_2", 2, 1);
        bus.rd_valid = 1; bus.rd_bank = 1; bus.rd_index = 1;
        @(posedge Clk);
        #2 Reset_n = 0;
        #1 lvl_chk("arst", 15, 0);
        chk("arst_v", int'(bus.out_valid), 0);
        @(negedge Clk);
        bus.rd_valid = 0;
        #2 Reset_n = 1;
        @(negedge Clk);
        chk("arst_v2", int'(bus.out_valid), 0);
        rd_chk("arst_pal", 1, 1, 0, 'h000, 0);

        repeat (3000) begin
            bus.wr_en = ($urandom_range(0, 2) == 0);
            bus.wr_bank = 2'($urandom);
            bus.wr_index = 4'($urandom);
            bus.wr_color = 12'($urandom);
            bus.rd_valid = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 3) == 0) begin
                bus.rd_bank = bus.wr_bank;
                bus.rd_index = bus.wr_index;
            end else begin
                bus.rd_bank = 2'($urandom);
                bus.rd_index = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            end
            bus.transp_en = $urandom_range(0, 1) != 0;
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            bus.fade_start = ($urandom_range(0, 59) == 0);
            bus.fade_dir = $urandom_range(0, 1) != 0;
            @(negedge Clk);
        end
        clr();
        repeat (4) @(negedge Clk);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
